// File: rtl/uart_frame_parser_pkg.sv
// Shared definitions for the UART command-frame parser: state encoding,
// error causes and default frame byte values.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OP,
        ST_A2,
        ST_A1,
        ST_A0,
        ST_DAT,
        ST_CSUM,
        ST_ISSUE
    } state_t;

    localparam logic [1:0] ERR_OVR  = 2'd0;
    localparam logic [1:0] ERR_OP   = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;
    localparam logic [1:0] ERR_TO   = 2'd3;

    localparam logic [7:0] DEF_HEADER = 8'hAA;
    localparam logic [7:0] DEF_OP_WR  = 8'h01;
    localparam logic [7:0] DEF_OP_SE  = 8'h02;

endpackage

// File: rtl/uart_frame_parser_timeout.sv
// Inter-byte timeout counter: clears on request, counts while enabled and
// flags expiry on the cycle it holds TO_CYC-1.
module frame_timeout_cnt #(
    parameter int TO_CYC = 520_833,
    parameter int TO_W   = 20
) (
    input  logic sclk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [TO_W-1:0] cnt;

    assign expire = en && (cnt == TO_W'(TO_CYC - 1));

    always_ff @(posedge sclk) begin
        if (rst || clr || expire) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles 7-byte command frames from the UART byte stream, validates them
// and hands each good frame to the flash controller on a valid/ready handshake.
//
//   state    | meaning
//   ---------+----------------------------------------------
//   IDLE     | hunting for the header byte
//   OP       | expecting the opcode
//   A2/A1/A0 | expecting address bytes, MSB first
//   DAT      | expecting the data byte
//   CSUM     | expecting the XOR checksum
//   ISSUE    | command presented, waiting for cmd_ready
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter logic [7:0] HEADER = DEF_HEADER,
    parameter logic [7:0] OP_WR  = DEF_OP_WR,
    parameter logic [7:0] OP_SE  = DEF_OP_SE,
    parameter int         TO_CYC = 520_833,
    parameter int         TO_W   = 20
) (
    input  logic        sclk,
    input  logic        rst,
    input  logic [7:0]  po_data,
    input  logic        po_flag,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_op,
    output logic [23:0] cmd_addr,
    output logic [7:0]  cmd_data,
    output logic        err_flag,
    output logic [1:0]  err_code
);

    state_t     state, state_nxt;
    logic [7:0] acc;
    logic       op_ok;
    logic       in_frame;
    logic       tmo_en, tmo_clr, tmo_expire;
    logic       err_set;
    logic [1:0] err_cause;

    assign op_ok     = (po_data == OP_WR) || (po_data == OP_SE);
    assign in_frame  = (state != ST_IDLE) && (state != ST_ISSUE);
    assign tmo_en    = in_frame && !po_flag;
    assign tmo_clr   = !in_frame || po_flag;
    assign cmd_valid = (state == ST_ISSUE);

    frame_timeout_cnt #(
        .TO_CYC (TO_CYC),
        .TO_W   (TO_W)
    ) u_timeout (
        .sclk   (sclk),
        .rst    (rst),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expire (tmo_expire)
    );

    always_ff @(posedge sclk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        err_cause = err_code;
        case (state)
            ST_IDLE: begin
                if (po_flag && (po_data == HEADER)) state_nxt = ST_OP;
            end
            ST_OP: begin
                if (po_flag) begin
                    if (op_ok) begin
                        state_nxt = ST_A2;
                    end else begin
                        state_nxt = ST_IDLE;
                        err_set   = 1'b1;
                        err_cause = ERR_OP;
                    end
                end
            end
            ST_A2:  if (po_flag) state_nxt = ST_A1;
            ST_A1:  if (po_flag) state_nxt = ST_A0;
            ST_A0:  if (po_flag) state_nxt = ST_DAT;
            ST_DAT: if (po_flag) state_nxt = ST_CSUM;
            ST_CSUM: begin
                if (po_flag) begin
                    if (po_data == acc) begin
                        state_nxt = ST_ISSUE;
                    end else begin
                        state_nxt = ST_IDLE;
                        err_set   = 1'b1;
                        err_cause = ERR_CSUM;
                    end
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) state_nxt = ST_IDLE;
                // A byte here is lost even when the handshake completes this cycle.
                if (po_flag) begin
                    err_set   = 1'b1;
                    err_cause = ERR_OVR;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (tmo_expire) begin
            state_nxt = ST_IDLE;
            err_set   = 1'b1;
            err_cause = ERR_TO;
        end
    end

    // Fields load straight into the outputs; nothing loads while in ISSUE,
    // so they stay stable for the whole handshake.
    always_ff @(posedge sclk) begin
        if (rst) begin
            acc      <= '0;
            cmd_op   <= '0;
            cmd_addr <= '0;
            cmd_data <= '0;
            err_flag <= 1'b0;
            err_code <= ERR_OVR;
        end else begin
            err_flag <= err_set;
            if (err_set) err_code <= err_cause;
            if (po_flag) begin
                case (state)
                    ST_OP: begin
                        if (op_ok) begin
                            cmd_op <= po_data;
                            acc    <= po_data;
                        end
                    end
                    ST_A2: begin
                        cmd_addr[23:16] <= po_data;
                        acc             <= acc ^ po_data;
                    end
                    ST_A1: begin
                        cmd_addr[15:8] <= po_data;
                        acc            <= acc ^ po_data;
                    end
                    ST_A0: begin
                        cmd_addr[7:0] <= po_data;
                        acc           <= acc ^ po_data;
                    end
                    ST_DAT: begin
                        cmd_data <= po_data;
                        acc      <= acc ^ po_data;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed scenarios plus random
// frames scored against a frame-level reference model.
module tb_uart_frame_parser;

    localparam int TO_CYC = 100;

    logic        sclk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  po_data = 8'h00;
    logic        po_flag = 1'b0;
    logic        cmd_ready = 1'b1;
    logic        cmd_valid;
    logic [7:0]  cmd_op;
    logic [23:0] cmd_addr;
    logic [7:0]  cmd_data;
    logic        err_flag;
    logic [1:0]  err_code;

    int vectors = 0;
    int miscompares = 0;
    int err_seen = 0;

    uart_frame_parser #(.TO_CYC(TO_CYC), .TO_W(20)) dut (
        .sclk      (sclk),
        .rst       (rst),
        .po_data   (po_data),
        .po_flag   (po_flag),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .err_flag  (err_flag),
        .err_code  (err_code)
    );

    always #5 sclk = ~sclk;

    always @(negedge sclk) if (err_flag) err_seen++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected to have finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge sclk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        po_data = b;
        po_flag = 1'b1;
        @(posedge sclk);
        #1;
        po_flag = 1'b0;
    endtask

    task automatic send_bytes(input logic [55:0] f, input int first, input int last);
        for (int i = first; i <= last; i++) send_byte(f[55-8*i -: 8]);
    endtask

    // Frame-level model: 0 = accepted, 1 = bad opcode, 2 = checksum error.
    function automatic int ref_outcome(input logic [55:0] f, output logic [39:0] exp_cmd);
        logic [7:0] b [7];
        logic [7:0] x;
        for (int i = 0; i < 7; i++) b[i] = f[55-8*i -: 8];
        exp_cmd = {b[1], b[2], b[3], b[4], b[5]};
        if (b[1] != 8'h01 && b[1] != 8'h02) return 1;
        x = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
        if (x != b[6]) return 2;
        return 0;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        vectors++; if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", cmd_valid); end
        vectors++; if ({cmd_op, cmd_addr, cmd_data} !== 40'h0) begin miscompares++; $display("FAIL reset_fields: got %h expected 0", {cmd_op, cmd_addr, cmd_data}); end
        vectors++; if (err_flag !== 1'b0) begin miscompares++; $display("FAIL reset_err_flag: got %b expected 0", err_flag); end
        vectors++; if (err_code !== 2'd0) begin miscompares++; $display("FAIL reset_err_code: got %0d expected 0", err_code); end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_good_frame();
        int e0 = err_seen;
        cmd_ready = 1'b1;
        send_bytes(56'hAA_01_12_34_56_78_09, 0, 5);
        vectors++; if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL good_early_valid: got %b expected 0", cmd_valid); end
        send_byte(8'h09);
        vectors++; if (cmd_valid !== 1'b1) begin miscompares++; $display("FAIL good_valid: got %b expected 1", cmd_valid); end
        vectors++; if ({cmd_op, cmd_addr, cmd_data} !== 40'h01_123456_78) begin miscompares++; $display("FAIL good_fields: got %h expected 0112345678", {cmd_op, cmd_addr, cmd_data}); end
        tick(1);
        vectors++; if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL good_drop: got %b expected 0", cmd_valid); end
        vectors++; if (err_seen - e0 !== 0) begin miscompares++; $display("FAIL good_no_err: got %0d errors expected 0", err_seen - e0); end
    endtask

    task automatic test_csum_err();
        send_bytes(56'hAA_01_12_34_56_78_08, 0, 6);
        vectors++; if (err_flag !== 1'b1 || err_code !== 2'd2) begin miscompares++; $display("FAIL csum_err: got flag %b code %0d expected 1/2", err_flag, err_code); end
        vectors++; if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL csum_no_valid: got %b expected 0", cmd_valid); end
        tick(1);
        vectors++; if (err_flag !== 1'b0 || err_code !== 2'd2) begin miscompares++; $display("FAIL csum_pulse_hold: got flag %b code %0d expected 0/2", err_flag, err_code); end
        send_bytes(56'hAA_01_12_34_56_78_09, 0, 6);
        vectors++; if (cmd_valid !== 1'b1 || {cmd_op, cmd_addr, cmd_data} !== 40'h01_123456_78) begin miscompares++; $display("FAIL csum_recover: got %b %h expected 1 0112345678", cmd_valid, {cmd_op, cmd_addr, cmd_data}); end
        tick(1);
    endtask

    task automatic test_bad_op();
        int e0 = err_seen;
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(8'h07);
        vectors++; if (err_flag !== 1'b1 || err_code !== 2'd1) begin miscompares++; $display("FAIL bad_op: got flag %b code %0d expected 1/1", err_flag, err_code); end
        tick(1);
        send_bytes(56'hAA_02_00_10_00_FF_ED, 0, 6);
        vectors++; if (cmd_valid !== 1'b1 || {cmd_op, cmd_addr, cmd_data} !== 40'h02_001000_FF) begin miscompares++; $display("FAIL erase_frame: got %b %h expected 1 02001000ff", cmd_valid, {cmd_op, cmd_addr, cmd_data}); end
        tick(1);
        vectors++; if (err_seen - e0 !== 1) begin miscompares++; $display("FAIL bad_op_err_count: got %0d expected 1", err_seen - e0); end
    endtask

    task automatic test_backpressure();
        cmd_ready = 1'b0;
        send_bytes(56'hAA_01_12_34_56_78_09, 0, 6);
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                send_byte(8'h5A);
                vectors++; if (err_flag !== 1'b1 || err_code !== 2'd0) begin miscompares++; $display("FAIL overrun: got flag %b code %0d expected 1/0", err_flag, err_code); end
            end else begin
                tick(1);
            end
            vectors++; if (cmd_valid !== 1'b1 || {cmd_op, cmd_addr, cmd_data} !== 40'h01_123456_78) begin miscompares++; $display("FAIL bp_stable[%0d]: got %b %h expected 1 0112345678", i, cmd_valid, {cmd_op, cmd_addr, cmd_data}); end
        end
        tick(1);
        cmd_ready = 1'b1;
        send_byte(8'h33);
        vectors++; if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release: got %b expected 0", cmd_valid); end
        vectors++; if (err_flag !== 1'b1 || err_code !== 2'd0) begin miscompares++; $display("FAIL bp_overrun_on_handshake: got flag %b code %0d expected 1/0", err_flag, err_code); end
        tick(1);
    endtask

    task automatic test_timeout();
        logic early = 1'b0;
        send_bytes(56'hAA_01_12_00_00_00_00, 0, 2);
        for (int i = 0; i < TO_CYC - 1; i++) begin
            tick(1);
            if (err_flag) early = 1'b1;
        end
        vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL timeout_early: got err_flag before %0d cycles expected none", TO_CYC); end
        tick(1);
        vectors++; if (err_flag !== 1'b1 || err_code !== 2'd3) begin miscompares++; $display("FAIL timeout: got flag %b code %0d expected 1/3", err_flag, err_code); end
        tick(1);
        send_bytes(56'hAA_01_12_34_56_78_09, 0, 2);
        tick(TO_CYC - 1);
        send_byte(8'h34);
        vectors++; if (err_flag !== 1'b0) begin miscompares++; $display("FAIL timeout_byte_wins: got err_flag %b expected 0", err_flag); end
        send_bytes(56'hAA_01_12_34_56_78_09, 4, 6);
        vectors++; if (cmd_valid !== 1'b1 || {cmd_op, cmd_addr, cmd_data} !== 40'h01_123456_78) begin miscompares++; $display("FAIL timeout_late_frame: got %b %h expected 1 0112345678", cmd_valid, {cmd_op, cmd_addr, cmd_data}); end
        tick(1);
    endtask

    task automatic test_reset_mid_frame();
        int e0;
        cmd_ready = 1'b1;
        send_bytes(56'hAA_01_12_34_56_78_09, 0, 3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        vectors++; if ({cmd_valid, cmd_op, cmd_addr, cmd_data, err_flag, err_code} !== 44'h0) begin miscompares++; $display("FAIL rst_mid_outputs: got %h expected 0", {cmd_valid, cmd_op, cmd_addr, cmd_data, err_flag, err_code}); end
        e0 = err_seen;
        send_bytes(56'hAA_01_12_34_56_78_09, 4, 6);
        vectors++; if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_tail_ignored: got %b expected 0", cmd_valid); end
        tick(1);
        vectors++; if (err_seen - e0 !== 0) begin miscompares++; $display("FAIL rst_mid_no_err: got %0d expected 0", err_seen - e0); end
        send_bytes(56'hAA_01_12_34_56_78_09, 0, 6);
        vectors++; if (cmd_valid !== 1'b1 || {cmd_op, cmd_addr, cmd_data} !== 40'h01_123456_78) begin miscompares++; $display("FAIL rst_mid_next_frame: got %b %h expected 1 0112345678", cmd_valid, {cmd_op, cmd_addr, cmd_data}); end
        tick(1);
        cmd_ready = 1'b0;
        send_bytes(56'hAA_02_00_10_00_FF_ED, 0, 6);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        vectors++; if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_handshake: got %b expected 0", cmd_valid); end
        cmd_ready = 1'b1;
        tick(1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int kind, outcome, hold, last, e0;
            logic [7:0]  op, junk, cs;
            logic [23:0] addr;
            logic [7:0]  data;
            logic [55:0] f;
            logic [39:0] exp_cmd;
            kind = $urandom_range(0, 2);
            if (kind == 1) begin
                do op = 8'($urandom); while (op == 8'h01 || op == 8'h02);
            end else begin
                op = ($urandom_range(0, 1) != 0) ? 8'h01 : 8'h02;
            end
            addr = 24'($urandom);
            data = 8'($urandom);
            cs = op ^ addr[23:16] ^ addr[15:8] ^ addr[7:0] ^ data;
            if (kind == 2) cs = cs ^ 8'($urandom_range(1, 255));
            f = {8'hAA, op, addr, data, cs};
            outcome = ref_outcome(f, exp_cmd);
            last = (outcome == 1) ? 1 : 6;
            hold = $urandom_range(0, 3);
            e0 = err_seen;
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
                do junk = 8'($urandom); while (junk == 8'hAA);
                send_byte(junk);
                tick($urandom_range(0, 3));
            end
            for (int i = 0; i <= last; i++) begin
                if (i == last) cmd_ready = (hold == 0);
                send_byte(f[55-8*i -: 8]);
                if (i != last) tick($urandom_range(0, 4));
            end
            if (outcome == 0) begin
                vectors++; if (cmd_valid !== 1'b1 || {cmd_op, cmd_addr, cmd_data} !== exp_cmd) begin miscompares++; $display("FAIL rnd_cmd[%0d]: got %b %h expected 1 %h", n, cmd_valid, {cmd_op, cmd_addr, cmd_data}, exp_cmd); end
                if (hold > 0) begin
                    tick(hold);
                    vectors++; if (cmd_valid !== 1'b1 || {cmd_op, cmd_addr, cmd_data} !== exp_cmd) begin miscompares++; $display("FAIL rnd_hold[%0d]: got %b %h expected 1 %h", n, cmd_valid, {cmd_op, cmd_addr, cmd_data}, exp_cmd); end
                    cmd_ready = 1'b1;
                end
                tick(1);
                vectors++; if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL rnd_drop[%0d]: got %b expected 0", n, cmd_valid); end
            end else begin
                vectors++; if (err_flag !== 1'b1 || err_code !== 2'(outcome) || cmd_valid !== 1'b0) begin miscompares++; $display("FAIL rnd_err[%0d]: got flag %b code %0d valid %b expected 1/%0d/0", n, err_flag, err_code, cmd_valid, outcome); end
                tick(1);
            end
            vectors++; if (err_seen - e0 !== ((outcome != 0) ? 1 : 0)) begin miscompares++; $display("FAIL rnd_err_count[%0d]: got %0d expected %0d", n, err_seen - e0, (outcome != 0) ? 1 : 0); end
            cmd_ready = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_csum_err();
        test_bad_op();
        test_backpressure();
        test_timeout();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
